// File: rtl/csr_shifter_pkg.sv
// Shared types and register map for the CSR-programmed multi-cycle shifter.
package csr_shifter_pkg;

    typedef enum logic [1:0] {
        MODE_LSL = 2'd0,
        MODE_LSR = 2'd1,
        MODE_ASR = 2'd2,
        MODE_ROR = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_CMD    = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_RESULT = 2'd3;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERR   = 2;
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

endpackage

// File: rtl/csr_shifter_step.sv
// Combinational single-step shifter: moves a word by 0..STEP positions.
module shift_step
    import csr_shifter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 1
) (
    input  logic [DATA_W-1:0]          data_i,
    input  mode_e                      mode_i,
    input  logic [$clog2(STEP+1)-1:0]  amt_i,
    output logic [DATA_W-1:0]          data_o
);

    logic [2*DATA_W-1:0] rot;

    assign rot = {data_i, data_i} >> amt_i;

    always_comb begin
        data_o = data_i;
        unique case (mode_i)
            MODE_LSL: data_o = data_i << amt_i;
            MODE_LSR: data_o = data_i >> amt_i;
            MODE_ASR: data_o = $signed(data_i) >>> amt_i;
            MODE_ROR: data_o = rot[DATA_W-1:0];
            default:  data_o = data_i;
        endcase
    end

endmodule

// File: rtl/csr_shifter.sv
// Memory-mapped shifter: DATA/CMD/CTRL/RESULT window, STEP bits per cycle.
module csr_shifter
    import csr_shifter_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          STEP      = 1,
    parameter logic [31:0] BASE_ADDR = 32'h000000F0
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        irq_o,
    output logic        busy_o
);

    localparam int RW = $clog2(DATA_W + 1);
    localparam int AW = $clog2(STEP + 1);
    localparam logic [RW-1:0] STEP_R = RW'(STEP);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d, op_mode_q, op_mode_d;
    logic [DATA_W-1:0] data_q, data_d, result_q, result_d;
    logic [DATA_W-1:0] work_q, work_d, work_nx;
    logic [7:0]        amt_q, amt_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic              done_q, done_d, err_q, err_d;
    logic              resp_q, resp_d;
    logic [31:0]       rdata_q, rdata_d;

    logic          hit, wr, rd, last;
    logic [1:0]    off;
    logic [7:0]    n_mod, e_full;
    logic [AW-1:0] step_amt;
    logic          unused_ok;

    assign unused_ok = ^{bus_be_bi, bus_addr_bi[1:0], bus_wdata_bi};

    assign hit = bus_addr_bi[31:4] == BASE_ADDR[31:4];
    assign off = bus_addr_bi[3:2];
    assign wr  = bus_req_i & bus_we_i & hit;
    assign rd  = bus_req_i & ~bus_we_i;

    // Rotations wrap modulo width; linear shifts saturate at full width.
    assign n_mod  = 8'({24'd0, amt_q} % DATA_W);
    assign e_full = (mode_q == MODE_ROR) ? n_mod :
                    (amt_q > 8'(DATA_W)) ? 8'(DATA_W) : amt_q;

    assign last     = rem_q <= STEP_R;
    assign step_amt = last ? AW'(rem_q) : AW'(STEP);

    shift_step #(
        .DATA_W (DATA_W),
        .STEP   (STEP)
    ) u_step (
        .data_i (work_q),
        .mode_i (op_mode_q),
        .amt_i  (step_amt),
        .data_o (work_nx)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        op_mode_d = op_mode_q;
        data_d    = data_q;
        result_d  = result_q;
        work_d    = work_q;
        amt_d     = amt_q;
        rem_d     = rem_q;
        done_d    = done_q;
        err_d     = err_q;
        resp_d    = rd;
        rdata_d   = '0;

        if (wr) begin
            unique case (off)
                OFF_DATA: data_d = bus_wdata_bi[DATA_W-1:0];
                OFF_CMD: begin
                    mode_d = mode_e'(bus_wdata_bi[1:0]);
                    amt_d  = bus_wdata_bi[15:8];
                end
                OFF_CTRL: begin
                    if (bus_wdata_bi[CTRL_CLEAR]) begin
                        done_d = 1'b0;
                        err_d  = 1'b0;
                    end
                    if (bus_wdata_bi[CTRL_START] && state_q == ST_RUN)
                        err_d = 1'b1;
                end
                default: ;
            endcase
        end

        // Completion is ordered after the clear so a coinciding clear loses.
        unique case (state_q)
            ST_IDLE: begin
                if (wr && off == OFF_CTRL && bus_wdata_bi[CTRL_START]) begin
                    state_d   = ST_RUN;
                    work_d    = data_q;
                    op_mode_d = mode_q;
                    rem_d     = RW'(e_full);
                    done_d    = 1'b0;
                end
            end
            ST_RUN: begin
                work_d = work_nx;
                rem_d  = rem_q - RW'(step_amt);
                if (last) begin
                    state_d  = ST_IDLE;
                    result_d = work_nx;
                    done_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd && hit) begin
            unique case (off)
                OFF_DATA:   rdata_d[DATA_W-1:0] = data_q;
                OFF_CMD: begin
                    rdata_d[1:0]  = mode_q;
                    rdata_d[15:8] = amt_q;
                end
                OFF_CTRL: begin
                    rdata_d[STAT_BUSY] = state_q == ST_RUN;
                    rdata_d[STAT_DONE] = done_q;
                    rdata_d[STAT_ERR]  = err_q;
                end
                OFF_RESULT: rdata_d[DATA_W-1:0] = result_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_LSL;
            op_mode_q <= MODE_LSL;
            data_q    <= '0;
            result_q  <= '0;
            work_q    <= '0;
            amt_q     <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            op_mode_q <= op_mode_d;
            data_q    <= data_d;
            result_q  <= result_d;
            work_q    <= work_d;
            amt_q     <= amt_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            err_q     <= err_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus_ack_o    = bus_req_i;
    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;
    assign irq_o        = done_q;
    assign busy_o       = state_q == ST_RUN;

endmodule

// File: tb/tb_csr_shifter.sv
// Randomised and directed bench for csr_shifter (DATA_W=32, STEP=4).
module tb_csr_shifter;

    localparam logic [31:0] BASE   = 32'h000000F0;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_CMD  = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_RES  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ack, resp, irq, busy;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    csr_shifter #(
        .DATA_W    (32),
        .STEP      (4),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .bus_req_i    (req),
        .bus_we_i     (we),
        .bus_addr_bi  (addr),
        .bus_be_bi    (be),
        .bus_wdata_bi (wdata),
        .bus_ack_o    (ack),
        .bus_resp_o   (resp),
        .bus_rdata_bo (rdata),
        .irq_o        (irq),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        chk("wr_noresp", {31'd0, resp}, 32'd0);
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a;
        #1 chk("rd_ack", {31'd0, ack}, 32'd1);
        @(negedge clk);
        req = 1'b0;
        chk("rd_resp", {31'd0, resp}, 32'd1);
        d = rdata;
    endtask

    // Reference: bit-level definition of each shift mode.
    function automatic logic [31:0] ref_shift(input int mode,
                                              input logic [31:0] d,
                                              input int n);
        logic [31:0] r;
        r = '0;
        case (mode)
            0: r = (n >= 32) ? 32'h0 : d << n;
            1: r = (n >= 32) ? 32'h0 : d >> n;
            2: for (int i = 0; i < 32; i++)
                   r[i] = (i + n > 31) ? d[31] : d[i+n];
            default: for (int i = 0; i < 32; i++)
                   r[i] = d[(i+n)%32];
        endcase
        return r;
    endfunction

    function automatic int ref_cycles(input int mode, input int n);
        int e;
        e = (mode == 3) ? n % 32 : ((n > 32) ? 32 : n);
        return (e == 0) ? 1 : (e + 3) / 4;
    endfunction

    function automatic logic [31:0] cmd_word(input int mode, input int n);
        logic [31:0] c;
        c = '0;
        c[1:0]  = mode[1:0];
        c[15:8] = n[7:0];
        return c;
    endfunction

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input int mode,
                          input logic [31:0] d, input int n,
                          output logic [31:0] res);
        logic [31:0] r;
        int cnt;
        bus_wr(A_DATA, d);
        bus_wr(A_CMD, cmd_word(mode, n));
        bus_wr(A_CTRL, 32'h1);
        wait_idle(cnt);
        chk({tag, "_busy"}, cnt, ref_cycles(mode, n));
        chk({tag, "_irq"}, {31'd0, irq}, 32'd1);
        bus_rd(A_RES, res);
        chk({tag, "_res"}, res, ref_shift(mode, d, n));
        bus_rd(A_CTRL, r);
        chk({tag, "_stat"}, r, 32'h2);
    endtask

    initial begin
        logic [31:0] r;
        int cnt;
        int m, n;
        logic [31:0] d;

        arst_n = 1'b0; req = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; be = 4'hF;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_resp", {31'd0, resp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        arst_n = 1'b1;
        bus_rd(A_DATA, r);   chk("rst_data", r, 32'd0);
        bus_rd(A_CMD, r);    chk("rst_cmd", r, 32'd0);
        bus_rd(A_CTRL, r);   chk("rst_stat", r, 32'd0);
        bus_rd(A_RES, r);    chk("rst_res", r, 32'd0);

        run_op("lsl4", 0, 32'h000000F0, 4, r);
        chk("lsl4_lit", r, 32'h00000F00);
        run_op("asr31", 2, 32'h80000000, 31, r);
        chk("asr31_lit", r, 32'hFFFFFFFF);
        run_op("ror33", 3, 32'h00000001, 33, r);
        chk("ror33_lit", r, 32'h80000000);
        run_op("lsr40", 1, 32'h00000001, 40, r);
        chk("lsr40_lit", r, 32'h0);
        run_op("lsl0", 0, 32'h00000001, 0, r);
        chk("lsl0_lit", r, 32'h00000001);
        bus_rd(A_CMD, r);
        chk("cmd_rb", r, 32'h00000000);
        bus_wr(A_CMD, 32'hFFFF_2D07);
        bus_rd(A_CMD, r);
        chk("cmd_rb2", r, 32'h00002D03);

        // Second start mid-run: flagged, original operation continues.
        bus_wr(A_DATA, 32'h12345678);
        bus_wr(A_CMD, cmd_word(0, 32));
        bus_wr(A_CTRL, 32'h1);
        @(negedge clk);
        bus_wr(A_CTRL, 32'h1);
        chk("err_busy", {31'd0, busy}, 32'd1);
        wait_idle(cnt);
        chk("err_cnt", cnt, 32'd5);
        bus_rd(A_CTRL, r); chk("err_stat", r, 32'h6);
        bus_rd(A_RES, r);  chk("err_res", r, 32'h0);
        bus_wr(A_CTRL, 32'h2);
        bus_rd(A_CTRL, r); chk("clr_stat", r, 32'h0);
        chk("clr_irq", {31'd0, irq}, 32'd0);

        // Register writes during RUN only affect the next operation.
        bus_wr(A_DATA, 32'hF0000000);
        bus_wr(A_CMD, cmd_word(2, 16));
        bus_wr(A_CTRL, 32'h1);
        bus_wr(A_DATA, 32'h0000ABCD);
        bus_wr(A_CMD, cmd_word(0, 4));
        wait_idle(cnt);
        bus_rd(A_RES, r);  chk("midrun_res", r, 32'hFFFFF000);
        bus_rd(A_DATA, r); chk("midrun_data", r, 32'h0000ABCD);

        // Clear in the completion cycle leaves done set.
        bus_wr(A_CTRL, 32'h3);
        req = 1'b1; we = 1'b1; addr = A_CTRL; wdata = 32'h2;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        chk("clr_race_irq", {31'd0, irq}, 32'd1);
        bus_rd(A_RES, r); chk("clr_race_res", r, 32'h000ABCD0);

        // Status read in the completion cycle sees pre-update value.
        bus_wr(A_CTRL, 32'h1);
        req = 1'b1; we = 1'b0; addr = A_CTRL;
        @(negedge clk);
        req = 1'b0;
        chk("stat_race", rdata, 32'h1);
        chk("stat_race_irq", {31'd0, irq}, 32'd1);

        // Outside the window.
        bus_rd(32'h00000108, r); chk("miss_rd", r, 32'h0);
        bus_wr(32'h00000108, 32'h1);
        chk("miss_busy", {31'd0, busy}, 32'd0);
        bus_wr(32'h00000100, 32'hDEADBEEF);
        bus_rd(A_DATA, r); chk("miss_data", r, 32'h0000ABCD);

        for (int i = 0; i < 40; i++) begin
            m = int'($urandom_range(0, 3));
            d = $urandom;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 40));
            run_op($sformatf("rnd%0d", i), m, d, n, r);
        end

        // Reset in the middle of an operation.
        bus_wr(A_DATA, 32'h80000000);
        bus_wr(A_CMD, cmd_word(2, 31));
        bus_wr(A_CTRL, 32'h1);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_irq", {31'd0, irq}, 32'd0);
        chk("ar_resp", {31'd0, resp}, 32'd0);
        chk("ar_rdata", rdata, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        req = 1'b1; we = 1'b1; addr = A_CTRL; wdata = 32'h1;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        chk("ar_start", {31'd0, busy}, 32'd1);
        wait_idle(cnt);
        bus_rd(A_RES, r);  chk("ar_res", r, 32'h0);
        bus_rd(A_DATA, r); chk("ar_data", r, 32'h0);
        bus_rd(A_CMD, r);  chk("ar_cmd", r, 32'h0);
        bus_rd(A_CTRL, r); chk("ar_stat", r, 32'h2);
        run_op("ar_post", 2, 32'h80000000, 31, r);
        chk("ar_post_lit", r, 32'hFFFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
